// File: rtl/seq_pp_multiplier_pkg.sv
// rtl/seq_pp_multiplier_pkg.sv - shared types and sizing for the sequential multiplier
package mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Default sizing; the top recomputes these from its own WIDTH parameter.
    localparam int DEF_WIDTH = 8;
    localparam int PW        = 2 * DEF_WIDTH;
    localparam int CW        = $clog2(DEF_WIDTH);

    // Row counter width, never below one bit.
    function automatic int cnt_bits(input int w);
        return (w < 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/seq_pp_multiplier_if.sv
// rtl/seq_pp_multiplier_if.sv - operand/product handshake bundle
interface seq_pp_multiplier_if #(
    parameter int WIDTH = 8
);
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic                 out_valid;
    logic                 out_ready;
    logic [2*WIDTH-1:0]   product;
    logic                 busy;

    // Upstream/downstream side: supplies operands and accepts products.
    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, product, busy
    );

    // Multiplier side.
    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, product, busy
    );
endinterface

// File: rtl/seq_pp_multiplier_pp_row_gen.sv
// rtl/seq_pp_multiplier_pp_row_gen.sv - one partial-product row: sel AND each bit of vec
module pp_row_gen #(
    parameter int WIDTH = 8
) (
    input  logic             i_sel,
    input  logic [WIDTH-1:0] i_vec,
    output logic [WIDTH-1:0] o_row
);

    genvar i;
    for (i = 0; i < WIDTH; i++) begin : g_bit
        assign o_row[i] = i_sel & i_vec[i];
    end

endmodule

// File: rtl/seq_pp_multiplier.sv
// rtl/seq_pp_multiplier.sv - iterative unsigned multiplier, one partial-product row per cycle
module seq_pp_multiplier
    import mult_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    seq_pp_multiplier_if.slave  bus
);

    localparam int PROD_W = 2 * WIDTH;
    localparam int CNT_W  = cnt_bits(WIDTH);
    localparam logic [CNT_W-1:0] LAST_ROW = CNT_W'(WIDTH - 1);

    state_t              r_state;
    state_t              w_state_next;
    logic [PROD_W-1:0]   r_acc;
    logic [CNT_W-1:0]    r_cnt;
    logic [WIDTH-1:0]    r_a_q;
    logic [WIDTH-1:0]    r_b_q;

    logic                w_accept;
    logic                w_last_row;
    logic [WIDTH-1:0]    w_row;
    logic [PROD_W-1:0]   w_row_shifted;

    // The multiplier bit picked by the row counter gates the whole multiplicand.
    pp_row_gen #(
        .WIDTH (WIDTH)
    ) u_row_gen (
        .i_sel (r_a_q[r_cnt]),
        .i_vec (r_b_q),
        .o_row (w_row)
    );

    assign w_row_shifted = PROD_W'(w_row) << r_cnt;
    assign w_last_row    = (r_cnt == LAST_ROW);
    assign w_accept      = (r_state == IDLE) && bus.in_valid;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and handshake outputs; the spare encoding falls back to IDLE.
    always_comb begin
        w_state_next  = IDLE;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        bus.busy      = 1'b0;
        case (r_state)
            IDLE: begin
                bus.in_ready = 1'b1;
                w_state_next = bus.in_valid ? RUN : IDLE;
            end
            RUN: begin
                bus.busy     = 1'b1;
                w_state_next = w_last_row ? DONE : RUN;
            end
            DONE: begin
                bus.busy      = 1'b1;
                bus.out_valid = 1'b1;
                w_state_next  = bus.out_ready ? IDLE : DONE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    // Operand capture on accept, then one shifted row added per RUN cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc <= '0;
            r_cnt <= '0;
            r_a_q <= '0;
            r_b_q <= '0;
        end else if (w_accept) begin
            r_a_q <= bus.a;
            r_b_q <= bus.b;
            r_acc <= '0;
            r_cnt <= '0;
        end else if (r_state == RUN) begin
            r_acc <= r_acc + w_row_shifted;
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    // Product comes straight from the accumulator register and holds after DONE.
    assign bus.product = r_acc;

endmodule
